spi_req_arbiter: RTL and testbench

//  Shares one spi_master byte engine between N_REQ requesters. Round-robin arbitration per transaction;
//  a transaction is one or more bytes, held locked to one requester until its byte flagged last completes.

---
 rtl/spi_pkg.sv | 17 +
 rtl/rr_pick.sv | 32 +++
 rtl/spi_req_arbiter.sv | 143 ++++++++++++++
 tb/tb_spi_req_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the SPI request arbiter.
package spi_pkg;

  localparam int SPI_BYTE_W      = 8;
  localparam int DEFAULT_TIMEOUT = 4096;
  localparam int DEFAULT_GAP     = 2;
  localparam int STATE_W         = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP,
    S_GAP
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit at or after the
// pointer, wrapping from N_REQ-1 back to 0.
module rr_pick import spi_pkg::*; #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic                     valid_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);

  localparam int PW = $clog2(N_REQ);
  localparam logic [PW:0] N_W = (PW+1)'(N_REQ);

  logic [PW:0] cand;

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      cand = {1'b0, ptr_i} + (PW+1)'(k);
      if (cand >= N_W) cand = cand - N_W;
      if (req_i[cand[PW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin sharing of one SPI byte engine between N_REQ requesters, with
// per-transaction locking, response return and a watchdog on the master's done.
module spi_req_arbiter import spi_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int GAP     = DEFAULT_GAP
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [SPI_BYTE_W*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]              req_last,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [SPI_BYTE_W-1:0]         rsp_data,
  output logic [N_REQ-1:0]              err,
  output logic [$clog2(N_REQ)-1:0]      owner,
  output logic                          busy,
  output logic [N_REQ-1:0]              dev_cs_n,
  output logic                          m_start,
  output logic [SPI_BYTE_W-1:0]         m_data_in,
  input  logic [SPI_BYTE_W-1:0]         m_data_out,
  input  logic                          m_done,
  input  logic                          m_cs
);

  localparam int PW    = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam int GAP_W = $clog2(GAP+1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT-1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP-1);
  localparam logic [PW-1:0]    IDX_LAST = PW'(N_REQ-1);

  arb_state_e             state_q;
  logic [PW-1:0]          owner_q, ptr_q, ptr_d, pick_idx;
  logic                   pick_valid;
  logic                   locked_q, last_q, first_q, done_q;
  logic [WD_W-1:0]        wd_q;
  logic [GAP_W-1:0]       gap_q;
  logic [N_REQ-1:0]       gnt_q, rsp_valid_q, err_q;
  logic [SPI_BYTE_W-1:0]  rsp_data_q, m_data_in_q;
  logic                   m_start_q;
  logic [SPI_BYTE_W-1:0]  req_byte [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign req_byte[i] = req_data[SPI_BYTE_W*i +: SPI_BYTE_W];
    assign dev_cs_n[i] = m_cs | ~(locked_q && (owner_q == PW'(i)));
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb ptr_d = (pick_idx == IDX_LAST) ? '0 : pick_idx + PW'(1);

  // The lock is taken at launch and only released when a byte flagged last
  // completes (or the watchdog fires), so the device select spans the burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      locked_q    <= 1'b0;
      last_q      <= 1'b0;
      first_q     <= 1'b0;
      done_q      <= 1'b0;
      wd_q        <= '0;
      gap_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      err_q       <= '0;
      rsp_data_q  <= '0;
      m_start_q   <= 1'b0;
      m_data_in_q <= '0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      err_q       <= '0;
      m_start_q   <= 1'b0;
      done_q      <= m_done;
      case (state_q)
        S_IDLE: begin
          if (locked_q) begin
            if (req[owner_q]) state_q <= S_LAUNCH;
          end else if (pick_valid) begin
            owner_q <= pick_idx;
            ptr_q   <= ptr_d;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          m_data_in_q    <= req_byte[owner_q];
          m_start_q      <= 1'b1;
          gnt_q[owner_q] <= 1'b1;
          locked_q       <= 1'b1;
          last_q         <= req_last[owner_q];
          wd_q           <= '0;
          first_q        <= 1'b1;
          state_q        <= S_WAIT;
        end
        S_WAIT: begin
          first_q <= 1'b0;
          // A done edge in the first cycle belongs to the previous byte.
          if (!first_q && m_done && !done_q) begin
            rsp_data_q           <= m_data_out;
            rsp_valid_q[owner_q] <= 1'b1;
            if (last_q) locked_q <= 1'b0;
            state_q              <= S_RESP;
          end else if (wd_q == WD_LAST) begin
            err_q[owner_q] <= 1'b1;
            locked_q       <= 1'b0;
            gap_q          <= '0;
            state_q        <= S_GAP;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        S_RESP: begin
          gap_q   <= '0;
          state_q <= S_GAP;
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) state_q <= S_IDLE;
          else                   gap_q   <= gap_q + GAP_W'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;
  assign owner     = owner_q;
  assign busy      = (state_q != S_IDLE);
  assign m_start   = m_start_q;
  assign m_data_in = m_data_in_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter: requester queues, a behavioural SPI
// master (rx = tx ^ 8'h99) and expected grant/response queues.
module tb_spi_req_arbiter;

  localparam int N   = 4;
  localparam int TO  = 4096;
  localparam int GP  = 2;
  localparam int LAT = 5;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req, req_last, gnt, rsp_valid, err, dev_cs_n;
  logic [8*N-1:0] req_data;
  logic [7:0]     rsp_data, m_data_in, m_data_out;
  logic [1:0]     owner;
  logic           busy, m_start, m_done, m_cs;

  typedef struct { int idx; logic [7:0] tx; } gntExp_t;
  typedef struct { int idx; logic [7:0] rx; bit isErr; } rspExp_t;
  typedef struct { logic [7:0] data; logic last; } reqByte_t;

  gntExp_t  expGnt[$];
  rspExp_t  expRsp[$];
  reqByte_t reqQ[N][$];

  int totalCnt = 0;
  int badCnt   = 0;
  int cyc      = 0;
  int startCyc = 0;
  int doneCyc  = 0;
  int mCnt     = 0;
  int reqRise[N];
  bit hangNext = 0, glitchNext = 0, latCheck = 0;
  bit mBusy = 0, mHang = 0, mGlitch = 0, prevStart = 0;
  logic [7:0] mTx;

  spi_req_arbiter #(.N_REQ(N), .TIMEOUT(TO), .GAP(GP)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .err        (err),
    .owner      (owner),
    .busy       (busy),
    .dev_cs_n   (dev_cs_n),
    .m_start    (m_start),
    .m_data_in  (m_data_in),
    .m_data_out (m_data_out),
    .m_done     (m_done),
    .m_cs       (m_cs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    if (obs !== exp) begin
      badCnt++;
      $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int ohIdx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic applyStimulus(input int idx, input logic [7:0] data, input logic last);
    reqByte_t b;
    b.data = data;
    b.last = last;
    reqQ[idx].push_back(b);
  endtask

  // kind: 0 = grant + response, 1 = grant + watchdog error, 2 = grant only
  task automatic pushExpect(input int idx, input logic [7:0] tx, input int kind);
    gntExp_t g;
    rspExp_t r;
    g.idx = idx;
    g.tx  = tx;
    expGnt.push_back(g);
    if (kind != 2) begin
      r.idx   = idx;
      r.rx    = tx ^ 8'h99;
      r.isErr = (kind == 1);
      expRsp.push_back(r);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int n = 0;
    int pend;
    pend = expGnt.size() + expRsp.size();
    for (int i = 0; i < N; i++) pend += reqQ[i].size();
    while ((pend != 0 || busy) && n < budget) begin
      tick();
      n++;
      pend = expGnt.size() + expRsp.size();
      for (int i = 0; i < N; i++) pend += reqQ[i].size();
    end
    checkOutput({tag, "Drain"}, 32'(pend), 0);
    checkOutput({tag, "IdleBusy"}, 32'(busy), 0);
    checkOutput({tag, "IdleCs"}, 32'(dev_cs_n), 32'hF);
  endtask

  // Monitor, master model and requester drivers, all evaluated mid-cycle.
  initial begin
    gntExp_t    g;
    rspExp_t    r;
    reqByte_t   b;
    logic [3:0] csExp;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        for (int i = 0; i < N; i++) reqQ[i].delete();
        req       = '0;
        req_last  = '0;
        prevStart = 1'b0;
        continue;
      end
      if (prevStart) checkOutput("startOneCycle", 32'(m_start), 0);
      prevStart = m_start;
      if (gnt != '0) begin
        checkOutput("gntOneHot", 32'($countones(gnt)), 1);
        if (expGnt.size() == 0) checkOutput("unexpectedGnt", 32'(gnt), 0);
        else begin
          g = expGnt.pop_front();
          checkOutput("gntIdx", 32'(ohIdx(gnt)), 32'(g.idx));
          checkOutput("gntTx", 32'(m_data_in), 32'(g.tx));
          checkOutput("gntStart", 32'(m_start), 1);
          if (latCheck) checkOutput("gntLatency", 32'(cyc - reqRise[g.idx]), 2);
        end
      end
      if (rsp_valid != '0 || err != '0) begin
        checkOutput("rspOneHot", 32'($countones({rsp_valid, err})), 1);
        if (expRsp.size() == 0) checkOutput("unexpectedRsp", 32'({rsp_valid, err}), 0);
        else begin
          r = expRsp.pop_front();
          checkOutput("rspIdx", 32'(ohIdx(rsp_valid | err)), 32'(r.idx));
          checkOutput("rspKind", 32'(|err), 32'(r.isErr));
          if (r.isErr) checkOutput("errLatency", 32'(cyc - startCyc), TO);
          else begin
            checkOutput("rspData", 32'(rsp_data), 32'(r.rx));
            checkOutput("rspLatency", 32'(cyc - doneCyc), 1);
          end
        end
        if (|err) begin
          mBusy = 1'b0;
          mHang = 1'b0;
          m_cs  = 1'b1;
        end
      end
      if (mBusy && !mHang && !mGlitch && mCnt == 0 && expRsp.size() > 0) begin
        csExp = ~(4'h1 << expRsp[0].idx);
        checkOutput("devCsDuringByte", 32'(dev_cs_n), 32'(csExp));
      end
      if (m_start) begin
        mTx      = m_data_in;
        mBusy    = 1'b1;
        mCnt     = LAT;
        m_cs     = 1'b0;
        startCyc = cyc;
        mHang    = hangNext;
        hangNext = 1'b0;
        if (glitchNext) begin
          m_done     = 1'b1;
          m_data_out = 8'hEE;
          mGlitch    = 1'b1;
          glitchNext = 1'b0;
        end else m_done = 1'b0;
      end else if (mGlitch) begin
        m_done  = 1'b0;
        mGlitch = 1'b0;
      end else if (mBusy && !mHang) begin
        if (mCnt == 0) begin
          m_done     = 1'b1;
          m_data_out = mTx ^ 8'h99;
          m_cs       = 1'b1;
          mBusy      = 1'b0;
          doneCyc    = cyc;
        end else mCnt--;
      end
      for (int i = 0; i < N; i++) begin
        if (gnt[i] && reqQ[i].size() > 0) b = reqQ[i].pop_front();
        if (reqQ[i].size() > 0) begin
          if (!req[i]) reqRise[i] = cyc;
          req[i]            = 1'b1;
          req_data[8*i +: 8] = reqQ[i][0].data;
          req_last[i]       = reqQ[i][0].last;
        end else begin
          req[i]      = 1'b0;
          req_last[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    req        = '0;
    req_last   = '0;
    req_data   = '0;
    m_done     = 1'b0;
    m_cs       = 1'b1;
    m_data_out = '0;
    repeat (3) tick();
    checkOutput("rstGnt", 32'(gnt), 0);
    checkOutput("rstRspValid", 32'(rsp_valid), 0);
    checkOutput("rstErr", 32'(err), 0);
    checkOutput("rstOwner", 32'(owner), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstCs", 32'(dev_cs_n), 32'hF);
    checkOutput("rstStart", 32'(m_start), 0);
    checkOutput("rstDataIn", 32'(m_data_in), 0);
    checkOutput("rstRspData", 32'(rsp_data), 0);
    rst = 1'b0;

    $display("[TB] single byte from requester 1");
    latCheck = 1'b1;
    applyStimulus(1, 8'hA5, 1'b1);
    pushExpect(1, 8'hA5, 0);
    waitDrain("single", 300);
    latCheck = 1'b0;
    checkOutput("singleRspHold", 32'(rsp_data), 32'h3C);
    checkOutput("singleOwner", 32'(owner), 1);

    $display("[TB] all requesters, round-robin order");
    doReset();
    for (int i = 0; i < N; i++) applyStimulus(i, 8'h10 + 8'(i), 1'b1);
    applyStimulus(0, 8'h20, 1'b1);
    for (int i = 0; i < N; i++) pushExpect(i, 8'h10 + 8'(i), 0);
    pushExpect(0, 8'h20, 0);
    waitDrain("roundRobin", 600);
    checkOutput("rrOwner", 32'(owner), 0);

    $display("[TB] locked 3-byte burst on requester 2");
    doReset();
    applyStimulus(2, 8'h41, 1'b0);
    applyStimulus(2, 8'h42, 1'b0);
    applyStimulus(2, 8'h43, 1'b1);
    for (int i = 0; i < 3; i++) pushExpect(2, 8'h41 + 8'(i), 0);
    repeat (3) tick();
    applyStimulus(0, 8'h50, 1'b1);
    pushExpect(0, 8'h50, 0);
    waitDrain("burst", 600);

    $display("[TB] watchdog abort");
    doReset();
    hangNext = 1'b1;
    applyStimulus(1, 8'h61, 1'b0);
    applyStimulus(3, 8'h73, 1'b1);
    pushExpect(1, 8'h61, 1);
    pushExpect(3, 8'h73, 0);
    waitDrain("watchdog", TO + 1000);

    $display("[TB] reset during WAIT");
    doReset();
    hangNext = 1'b1;
    applyStimulus(0, 8'h7E, 1'b1);
    pushExpect(0, 8'h7E, 2);
    for (int n = 0; n < 100 && expGnt.size() > 0; n++) tick();
    checkOutput("midGntSeen", 32'(expGnt.size()), 0);
    repeat (10) tick();
    checkOutput("midBusy", 32'(busy), 1);
    checkOutput("midCs", 32'(dev_cs_n), 32'hE);
    rst = 1'b1;
    tick();
    checkOutput("postRstBusy", 32'(busy), 0);
    checkOutput("postRstCs", 32'(dev_cs_n), 32'hF);
    checkOutput("postRstPulses", 32'({gnt, rsp_valid, err}), 0);
    rst = 1'b0;
    repeat (20) tick();
    checkOutput("postRstIdle", 32'(busy), 0);

    $display("[TB] stale done in first WAIT cycle");
    glitchNext = 1'b1;
    applyStimulus(2, 8'h5A, 1'b1);
    pushExpect(2, 8'h5A, 0);
    waitDrain("stale", 300);
    checkOutput("staleRspHold", 32'(rsp_data), 32'(8'h5A ^ 8'h99));

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
